eth_rx_frame_writer: RTL and testbench

- Upstream feeder for the ethernet IP's AXI4-Lite master path.
- Accepts the received byte stream from the MAC and packs it into little-endian 32-bit words.
- Buffers words in an internal FIFO and writes each frame into a ring of fixed-size memory slots over AXI4-Lite.
- After the last data word of a frame, writes a status/length word at offset 0 of that frame's slot.

---
 rtl/eth_rx_frame_writer.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_eth_rx_frame_writer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_frame_writer.sv
// eth_rx_frame_writer: packs the MAC receive byte stream into little-endian
// 32-bit words, buffers them in a word FIFO and writes each frame into a ring
// of fixed-size memory slots over AXI4-Lite. After the last data word, a
// status/length word is written at offset 0 of the frame's slot.
//
// Ports:
//   ACLK, ARESET        clock, asynchronous active-high reset
//   s_rx_*              byte stream from the MAC (tuser = error, on tlast beat)
//   m_axi_aw*/w*/b*     AXI4-Lite write master (one transaction outstanding)
//   frame_done          one-cycle pulse when a frame's status write completes
//   frame_len           byte length of the last completed frame (saturating)
//   frame_slot          slot index of the last completed frame
//   axi_error           sticky, set on any non-OKAY write response
module eth_rx_frame_writer #(
   parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
   parameter int unsigned SLOT_BYTES = 2048,
   parameter int unsigned NUM_SLOTS  = 8,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                         ACLK,
   input  logic                         ARESET,
   input  logic [7:0]                   s_rx_tdata,
   input  logic                         s_rx_tvalid,
   output logic                         s_rx_tready,
   input  logic                         s_rx_tlast,
   input  logic                         s_rx_tuser,
   output logic [31:0]                  m_axi_awaddr,
   output logic [2:0]                   m_axi_awprot,
   output logic                         m_axi_awvalid,
   input  logic                         m_axi_awready,
   output logic [31:0]                  m_axi_wdata,
   output logic [3:0]                   m_axi_wstrb,
   output logic                         m_axi_wvalid,
   input  logic                         m_axi_wready,
   input  logic [1:0]                   m_axi_bresp,
   input  logic                         m_axi_bvalid,
   output logic                         m_axi_bready,
   output logic                         frame_done,
   output logic [15:0]                  frame_len,
   output logic [$clog2(NUM_SLOTS)-1:0] frame_slot,
   output logic                         axi_error
);

   localparam int unsigned SW         = $clog2(NUM_SLOTS);
   localparam int unsigned FAW        = $clog2(FIFO_DEPTH);
   localparam int unsigned CW         = FAW + 1;
   localparam int unsigned SLOT_SHIFT = $clog2(SLOT_BYTES);
   localparam int unsigned KW         = SLOT_SHIFT - 2;
   localparam int unsigned MAX_BYTES  = SLOT_BYTES - 4;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
      logic        last;
      logic [15:0] len;
      logic        bad;
      logic        ovf;
   } entry_t;

   typedef enum logic [1:0] {IDLE, WRITE, RESP, STATUS} state_t;

   assign m_axi_awprot = 3'b000;

   // ---------------- byte packer ----------------
   logic [31:0] pk_data;
   logic [1:0]  pk_idx;
   logic [15:0] pk_cnt;
   logic        pk_ovf;

   logic        beat_c;
   logic        stored_c;
   logic [15:0] cnt_inc_c;
   logic [31:0] word_c;
   logic [2:0]  nbytes_c;
   logic [3:0]  strb_c;
   logic        push_c;
   entry_t      push_entry_c;

   assign beat_c = s_rx_tvalid & s_rx_tready;

   // Place the incoming byte and build the FIFO entry for this beat.
   always_comb begin
      stored_c  = (32'(pk_cnt) < MAX_BYTES);
      cnt_inc_c = (pk_cnt == 16'hFFFF) ? pk_cnt : pk_cnt + 16'd1;
      word_c    = pk_data;
      if (stored_c) begin
         case (pk_idx)
            2'd0:    word_c[7:0]   = s_rx_tdata;
            2'd1:    word_c[15:8]  = s_rx_tdata;
            2'd2:    word_c[23:16] = s_rx_tdata;
            default: word_c[31:24] = s_rx_tdata;
         endcase
      end
      nbytes_c = {1'b0, pk_idx} + (stored_c ? 3'd1 : 3'd0);
      case (nbytes_c)
         3'd1:    strb_c = 4'b0001;
         3'd2:    strb_c = 4'b0011;
         3'd3:    strb_c = 4'b0111;
         3'd4:    strb_c = 4'b1111;
         default: strb_c = 4'b0000;
      endcase
      push_c            = beat_c & (s_rx_tlast | (stored_c & (pk_idx == 2'd3)));
      push_entry_c.data = word_c;
      push_entry_c.strb = strb_c;
      push_entry_c.last = s_rx_tlast;
      push_entry_c.len  = cnt_inc_c;
      push_entry_c.bad  = s_rx_tlast & s_rx_tuser;
      push_entry_c.ovf  = pk_ovf | ~stored_c;
   end

   // Packer state; tlast restarts everything for the next frame.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         pk_data <= '0;
         pk_idx  <= '0;
         pk_cnt  <= '0;
         pk_ovf  <= 1'b0;
      end else if (beat_c) begin
         if (s_rx_tlast) begin
            pk_data <= '0;
            pk_idx  <= '0;
            pk_cnt  <= '0;
            pk_ovf  <= 1'b0;
         end else begin
            pk_cnt <= cnt_inc_c;
            pk_ovf <= pk_ovf | ~stored_c;
            if (stored_c) begin
               if (pk_idx == 2'd3) begin
                  pk_data <= '0;
                  pk_idx  <= '0;
               end else begin
                  pk_data <= word_c;
                  pk_idx  <= pk_idx + 2'd1;
               end
            end
         end
      end
   end

   // ---------------- word FIFO ----------------
   entry_t           mem [FIFO_DEPTH];
   logic [FAW-1:0]   wr_ptr;
   logic [FAW-1:0]   rd_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_next_c;
   logic             pop_c;
   entry_t           head_c;

   assign head_c       = mem[rd_ptr];
   assign count_next_c = count + CW'(push_c) - CW'(pop_c);

   // Pointers, occupancy and the registered ready (not full).
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         s_rx_tready <= 1'b1;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + FAW'(1);
         if (pop_c)  rd_ptr <= rd_ptr + FAW'(1);
         count       <= count_next_c;
         s_rx_tready <= (count_next_c != CW'(FIFO_DEPTH));
      end
   end

   // Storage array, no reset needed.
   always_ff @(posedge ACLK) begin
      if (push_c) mem[wr_ptr] <= push_entry_c;
   end

   // ---------------- AXI writer FSM ----------------
   state_t          state, state_d;
   logic            is_status, is_status_d;
   logic [SW-1:0]   slot_idx, slot_idx_d;
   logic [KW-1:0]   word_k, word_k_d;
   logic [15:0]     stat_len, stat_len_d;
   logic [31:0]     awaddr_d, wdata_d;
   logic [3:0]      wstrb_d;
   logic            awvalid_d, wvalid_d, bready_d;
   logic            frame_done_d, axi_error_d;
   logic [15:0]     frame_len_d;
   logic [SW-1:0]   frame_slot_d;

   logic [31:0]     slot_base_c;
   logic [31:0]     data_addr_c;
   logic [31:0]     status_word_c;

   assign slot_base_c   = BASE_ADDR + (32'(slot_idx) << SLOT_SHIFT);
   assign data_addr_c   = slot_base_c + 32'd4 + (32'(word_k) << 2);
   assign status_word_c = {head_c.bad, head_c.ovf, 14'd0, head_c.len};

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state         <= IDLE;
         is_status     <= 1'b0;
         slot_idx      <= '0;
         word_k        <= '0;
         stat_len      <= '0;
         m_axi_awaddr  <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_wdata   <= '0;
         m_axi_wstrb   <= '0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         frame_done    <= 1'b0;
         frame_len     <= '0;
         frame_slot    <= '0;
         axi_error     <= 1'b0;
      end else begin
         state         <= state_d;
         is_status     <= is_status_d;
         slot_idx      <= slot_idx_d;
         word_k        <= word_k_d;
         stat_len      <= stat_len_d;
         m_axi_awaddr  <= awaddr_d;
         m_axi_awvalid <= awvalid_d;
         m_axi_wdata   <= wdata_d;
         m_axi_wstrb   <= wstrb_d;
         m_axi_wvalid  <= wvalid_d;
         m_axi_bready  <= bready_d;
         frame_done    <= frame_done_d;
         frame_len     <= frame_len_d;
         frame_slot    <= frame_slot_d;
         axi_error     <= axi_error_d;
      end
   end

   // Next state and next registered outputs.
   always_comb begin
      state_d      = state;
      is_status_d  = is_status;
      slot_idx_d   = slot_idx;
      word_k_d     = word_k;
      stat_len_d   = stat_len;
      awaddr_d     = m_axi_awaddr;
      awvalid_d    = m_axi_awvalid;
      wdata_d      = m_axi_wdata;
      wstrb_d      = m_axi_wstrb;
      wvalid_d     = m_axi_wvalid;
      bready_d     = m_axi_bready;
      frame_done_d = 1'b0;
      frame_len_d  = frame_len;
      frame_slot_d = frame_slot;
      axi_error_d  = axi_error;
      pop_c        = 1'b0;

      case (state)
         IDLE: begin
            if (count != '0) begin
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               if (head_c.strb == 4'b0000) begin
                  // Truncated frame ended with nothing stored: go straight to status.
                  pop_c       = 1'b1;
                  awaddr_d    = slot_base_c;
                  wdata_d     = status_word_c;
                  wstrb_d     = 4'hF;
                  stat_len_d  = head_c.len;
                  is_status_d = 1'b1;
                  state_d     = STATUS;
               end else begin
                  awaddr_d    = data_addr_c;
                  wdata_d     = head_c.data;
                  wstrb_d     = head_c.strb;
                  is_status_d = 1'b0;
                  state_d     = WRITE;
               end
            end
         end

         WRITE, STATUS: begin
            awvalid_d = m_axi_awvalid & ~m_axi_awready;
            wvalid_d  = m_axi_wvalid & ~m_axi_wready;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = RESP;
            end
         end

         RESP: begin
            if (m_axi_bvalid) begin
               bready_d = 1'b0;
               if (m_axi_bresp != 2'b00) axi_error_d = 1'b1;
               if (is_status) begin
                  frame_done_d = 1'b1;
                  frame_len_d  = stat_len;
                  frame_slot_d = slot_idx;
                  slot_idx_d   = slot_idx + SW'(1);
                  word_k_d     = '0;
                  is_status_d  = 1'b0;
                  state_d      = IDLE;
               end else begin
                  pop_c    = 1'b1;
                  word_k_d = word_k + KW'(1);
                  if (head_c.last) begin
                     awvalid_d   = 1'b1;
                     wvalid_d    = 1'b1;
                     awaddr_d    = slot_base_c;
                     wdata_d     = status_word_c;
                     wstrb_d     = 4'hF;
                     stat_len_d  = head_c.len;
                     is_status_d = 1'b1;
                     state_d     = STATUS;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_eth_rx_frame_writer.sv
module tb_eth_rx_frame_writer;

   localparam logic [31:0] BASE  = 32'h4000_0000;
   localparam int          SLOT  = 2048;
   localparam int          NSLOT = 8;
   localparam int          MAXB  = SLOT - 4;

   logic        ACLK, ARESET;
   logic [7:0]  s_rx_tdata;
   logic        s_rx_tvalid, s_rx_tready, s_rx_tlast, s_rx_tuser;
   logic [31:0] m_axi_awaddr, m_axi_wdata;
   logic [2:0]  m_axi_awprot;
   logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
   logic [3:0]  m_axi_wstrb;
   logic [1:0]  m_axi_bresp;
   logic        m_axi_bvalid, m_axi_bready;
   logic        frame_done, axi_error;
   logic [15:0] frame_len;
   logic [2:0]  frame_slot;

   eth_rx_frame_writer #(
      .BASE_ADDR(BASE), .SLOT_BYTES(SLOT), .NUM_SLOTS(NSLOT), .FIFO_DEPTH(16)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .s_rx_tdata(s_rx_tdata), .s_rx_tvalid(s_rx_tvalid), .s_rx_tready(s_rx_tready),
      .s_rx_tlast(s_rx_tlast), .s_rx_tuser(s_rx_tuser),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .frame_done(frame_done), .frame_len(frame_len), .frame_slot(frame_slot),
      .axi_error(axi_error)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } wr_t;

   typedef struct {
      logic [15:0] len;
      logic [2:0]  slot;
   } fd_t;

   wr_t  exp_wr[$];
   wr_t  wr_log[$];
   fd_t  exp_fd[$];
   int   frame_bytes[$];

   int   checks = 0;
   int   errors = 0;

   int   model_slot = 0;
   bit   err_exp = 1'b0;

   // slave behaviour: 0 zero-wait, 1 random, 2 awready held by aw_hold
   int   mode = 0;
   bit   aw_hold = 1'b0;
   int   err_at = 0;
   bit   rand_err = 1'b0;
   bit   check_wr = 1'b1;
   bit   saw_tready_low = 1'b0;

   bit          aw_seen, w_seen, pend, b_hs_prev;
   bit          aw_wait_prev, w_wait_prev, aw_hs_prev, w_hs_prev;
   logic [31:0] cap_addr, cap_data, aw_addr_prev, w_data_prev;
   logic [3:0]  cap_strb, w_strb_prev;
   int          txn_cnt;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model: expected AXI writes and completion for one whole frame.
   task automatic model_frame(input int len, input bit tuser);
      int          n, nw, slot;
      logic [31:0] base;
      logic [31:0] d;
      logic [3:0]  s;
      logic [15:0] lsat;
      wr_t         w;
      fd_t         f;
      n    = (len < MAXB) ? len : MAXB;
      nw   = (n + 3) / 4;
      slot = model_slot;
      base = BASE + 32'(slot * SLOT);
      for (int k = 0; k < nw; k++) begin
         d = '0;
         s = '0;
         for (int j = 0; j < 4; j++) begin
            if (4 * k + j < n) begin
               d[8*j +: 8] = 8'(frame_bytes[4*k+j]);
               s[j]        = 1'b1;
            end
         end
         w.addr = base + 32'(4 + 4 * k);
         w.data = d;
         w.strb = s;
         exp_wr.push_back(w);
      end
      lsat   = (len > 65535) ? 16'hFFFF : 16'(len);
      w.addr = base;
      w.data = {tuser, (len > MAXB), 14'd0, lsat};
      w.strb = 4'hF;
      exp_wr.push_back(w);
      f.len  = lsat;
      f.slot = 3'(slot);
      exp_fd.push_back(f);
      model_slot = (model_slot + 1) % NSLOT;
   endtask

   // Drive frame_bytes[0..len-1] onto the stream with random idle gaps.
   task automatic drive_bytes(input int len, input bit tuser, input int gap_pct, input bit with_last);
      int i = 0;
      int waited = 0;
      bit holding = 1'b0;
      while (i < len) begin
         @(negedge ACLK);
         if (!holding) begin
            if ($urandom_range(99) < gap_pct) begin
               s_rx_tvalid = 1'b0;
               s_rx_tlast  = 1'b0;
               s_rx_tuser  = 1'b0;
               continue;
            end
            s_rx_tvalid = 1'b1;
            s_rx_tdata  = 8'(frame_bytes[i]);
            s_rx_tlast  = with_last && (i == len - 1);
            s_rx_tuser  = tuser && with_last && (i == len - 1);
         end
         if (s_rx_tready) begin
            i++;
            holding = 1'b0;
            waited  = 0;
         end else begin
            holding = 1'b1;
            waited++;
            if (waited > 5000) begin
               check("tready_timeout", 64'(waited), 64'd0);
               break;
            end
         end
      end
      @(negedge ACLK);
      s_rx_tvalid = 1'b0;
      s_rx_tlast  = 1'b0;
      s_rx_tuser  = 1'b0;
   endtask

   task automatic send_frame(input int len, input bit tuser, input int gap_pct, input bit ramp);
      frame_bytes.delete();
      for (int i = 0; i < len; i++) frame_bytes.push_back(ramp ? (i & 255) : int'($urandom_range(255)));
      model_frame(len, tuser);
      drive_bytes(len, tuser, gap_pct, 1'b1);
   endtask

   task automatic wait_done();
      int c = 0;
      while ((exp_wr.size() != 0 || exp_fd.size() != 0) && c < 20000) begin
         @(negedge ACLK);
         c++;
      end
      check("drain_outstanding", 64'(exp_wr.size() + exp_fd.size()), 64'd0);
      repeat (4) @(negedge ACLK);
   endtask

   task automatic do_reset();
      @(negedge ACLK);
      #1;
      ARESET      = 1'b1;
      s_rx_tvalid = 1'b0;
      s_rx_tlast  = 1'b0;
      s_rx_tuser  = 1'b0;
      repeat (3) @(negedge ACLK);
      check("rst_tready", 64'(s_rx_tready), 64'd1);
      check("rst_flags", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, frame_done, axi_error}), 64'd0);
      check("rst_bus", {m_axi_awaddr, m_axi_wdata}, 64'd0);
      check("rst_misc", 64'({m_axi_wstrb, m_axi_awprot, frame_len, frame_slot}), 64'd0);
      #1;
      ARESET = 1'b0;
      exp_wr.delete();
      exp_fd.delete();
      wr_log.delete();
      model_slot = 0;
      err_exp    = 1'b0;
      repeat (2) @(negedge ACLK);
   endtask

   // AXI slave plus the per-cycle compare against the model.
   always @(negedge ACLK) begin
      bit aw_hs, w_hs, b_hs;
      wr_t w;
      fd_t f;
      if (ARESET) begin
         m_axi_awready = 1'b0;
         m_axi_wready  = 1'b0;
         m_axi_bvalid  = 1'b0;
         m_axi_bresp   = 2'b00;
         aw_seen = 0; w_seen = 0; pend = 0; b_hs_prev = 0;
         aw_wait_prev = 0; w_wait_prev = 0; aw_hs_prev = 0; w_hs_prev = 0;
         txn_cnt = 0;
      end else begin
         if (aw_wait_prev)
            check("awvalid_hold", {31'd0, m_axi_awvalid, m_axi_awaddr}, {31'd0, 1'b1, aw_addr_prev});
         if (w_wait_prev)
            check("wvalid_hold", {27'd0, m_axi_wvalid, m_axi_wstrb, m_axi_wdata}, {27'd0, 1'b1, w_strb_prev, w_data_prev});
         if (aw_hs_prev) check("awvalid_drop", 64'(m_axi_awvalid), 64'd0);
         if (w_hs_prev)  check("wvalid_drop", 64'(m_axi_wvalid), 64'd0);
         check("axi_error_sticky", 64'(axi_error), 64'(err_exp));
         if (frame_done) begin
            if (exp_fd.size() == 0) begin
               check("frame_done_unexpected", 64'd1, 64'd0);
            end else begin
               f = exp_fd.pop_front();
               check("frame_len", 64'(frame_len), 64'(f.len));
               check("frame_slot", 64'(frame_slot), 64'(f.slot));
            end
         end
         if (!s_rx_tready) saw_tready_low = 1'b1;

         if (b_hs_prev) m_axi_bvalid = 1'b0;
         case (mode)
            0: begin m_axi_awready = 1'b1; m_axi_wready = 1'b1; end
            2: begin m_axi_awready = !aw_hold; m_axi_wready = 1'b1; end
            default: begin
               m_axi_awready = ($urandom_range(99) < 70);
               m_axi_wready  = ($urandom_range(99) < 70);
            end
         endcase
         if (!m_axi_bvalid && pend && (mode != 1 || $urandom_range(99) < 50)) begin
            txn_cnt++;
            m_axi_bvalid = 1'b1;
            m_axi_bresp  = ((txn_cnt == err_at) || (rand_err && $urandom_range(99) < 3)) ? 2'b10 : 2'b00;
            pend = 1'b0;
         end

         aw_hs = m_axi_awvalid && m_axi_awready;
         w_hs  = m_axi_wvalid && m_axi_wready;
         b_hs  = m_axi_bvalid && m_axi_bready;
         if (aw_hs) begin aw_seen = 1'b1; cap_addr = m_axi_awaddr; end
         if (w_hs)  begin w_seen = 1'b1; cap_data = m_axi_wdata; cap_strb = m_axi_wstrb; end
         if (aw_seen && w_seen) begin
            w.addr = cap_addr;
            w.data = cap_data;
            w.strb = cap_strb;
            wr_log.push_back(w);
            if (check_wr) begin
               if (exp_wr.size() == 0) begin
                  check("write_unexpected", {cap_addr, cap_data}, 64'd0);
               end else begin
                  w = exp_wr.pop_front();
                  check("write_addr_data", {cap_addr, cap_data}, {w.addr, w.data});
                  check("write_strb", 64'(cap_strb), 64'(w.strb));
               end
            end
            aw_seen = 1'b0;
            w_seen  = 1'b0;
            pend    = 1'b1;
         end
         if (b_hs && m_axi_bresp != 2'b00) err_exp = 1'b1;
         b_hs_prev    = b_hs;
         aw_hs_prev   = aw_hs;
         w_hs_prev    = w_hs;
         aw_wait_prev = m_axi_awvalid && !m_axi_awready;
         w_wait_prev  = m_axi_wvalid && !m_axi_wready;
         aw_addr_prev = m_axi_awaddr;
         w_data_prev  = m_axi_wdata;
         w_strb_prev  = m_axi_wstrb;
      end
   end

   initial begin
      int lens[8];
      ARESET        = 1'b1;
      s_rx_tdata    = 8'd0;
      s_rx_tvalid   = 1'b0;
      s_rx_tlast    = 1'b0;
      s_rx_tuser    = 1'b0;
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      m_axi_bvalid  = 1'b0;
      m_axi_bresp   = 2'b00;
      repeat (2) @(negedge ACLK);

      // 60-byte ramp frame, zero-wait slave
      mode = 0;
      do_reset();
      send_frame(60, 1'b0, 0, 1'b1);
      wait_done();
      check("f60_count", 64'(wr_log.size()), 64'd16);
      check("f60_first", {wr_log[0].addr, wr_log[0].data}, {32'h4000_0004, 32'h0302_0100});
      check("f60_status", {wr_log[15].addr, wr_log[15].data}, {32'h4000_0000, 32'h0000_003C});
      check("f60_len_slot", 64'({frame_len, frame_slot}), 64'({16'd60, 3'd0}));

      // 61-byte ramp frame: final single-byte word
      do_reset();
      send_frame(61, 1'b0, 20, 1'b1);
      wait_done();
      check("f61_last_data", {28'd0, wr_log[15].strb, wr_log[15].addr}, {28'd0, 4'b0001, 32'h4000_0040});
      check("f61_last_byte", 64'(wr_log[15].data), 64'h0000_003C);
      check("f61_status", 64'(wr_log[16].data), 64'h0000_003D);

      // Errored frame, then an oversized frame that is truncated
      mode = 1;
      do_reset();
      send_frame(20, 1'b1, 10, 1'b0);
      send_frame(2100, 1'b0, 5, 1'b0);
      wait_done();
      check("trunc_count", 64'(wr_log.size()), 64'd518);
      check("bad_status", 64'(wr_log[5].data), 64'h8000_0014);
      check("trunc_status", {wr_log[517].addr, wr_log[517].data}, {32'h4000_0800, 32'h4000_0834});

      // awready stalled: FIFO must fill and backpressure without losing bytes
      mode = 2;
      aw_hold = 1'b1;
      saw_tready_low = 1'b0;
      do_reset();
      fork
         send_frame(200, 1'b0, 0, 1'b0);
         begin
            int c = 0;
            while (!saw_tready_low && c < 400) begin @(negedge ACLK); c++; end
            repeat (20) @(negedge ACLK);
            aw_hold = 1'b0;
         end
      join
      wait_done();
      check("backpressure_seen", 64'(saw_tready_low), 64'd1);

      // SLVERR on the third write response
      mode = 1;
      err_at = 3;
      do_reset();
      send_frame(40, 1'b0, 10, 1'b0);
      wait_done();
      check("slverr_flag", 64'(axi_error), 64'd1);
      err_at = 0;
      send_frame(12, 1'b0, 10, 1'b0);
      wait_done();
      check("slverr_sticky", 64'(axi_error), 64'd1);

      // Nine 64-byte frames wrap the slot ring
      do_reset();
      for (int f = 0; f < 9; f++) send_frame(64, 1'b0, 10, 1'b0);
      wait_done();
      check("wrap_count", 64'(wr_log.size()), 64'd153);
      check("slot7_status_addr", 64'(wr_log[135].addr), 64'h4000_3800);
      check("wrap_status", {wr_log[152].addr, wr_log[152].data}, {32'h4000_0000, 32'h0000_0040});

      // Reset in the middle of frame 10; next frame lands in slot 0
      check_wr = 1'b0;
      frame_bytes.delete();
      for (int i = 0; i < 30; i++) frame_bytes.push_back(int'($urandom_range(255)));
      drive_bytes(30, 1'b0, 0, 1'b0);
      repeat (5) @(negedge ACLK);
      do_reset();
      check_wr = 1'b1;
      send_frame(8, 1'b0, 0, 1'b0);
      wait_done();
      check("post_rst_status", {wr_log[2].addr, wr_log[2].data}, {32'h4000_0000, 32'h0000_0008});
      check("post_rst_slot", 64'(frame_slot), 64'd0);

      // Boundary lengths then random frames against the model
      rand_err = 1'b1;
      do_reset();
      lens = '{1, 2, 3, 4, 5, 2044, 2045, 2047};
      foreach (lens[i]) send_frame(lens[i], 1'($urandom_range(1)), 15, 1'b0);
      for (int f = 0; f < 10; f++) send_frame(int'($urandom_range(130, 1)), 1'($urandom_range(1)), 20, 1'b0);
      wait_done();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
